pdm_decoder: RTL



---
 rtl/pdm_decoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pdm_decoder.sv
// PDM receive path: pin synchroniser, bit-rate prescaler, CIC decimator and saturating scaler.
// Define PDM_DECODER_CIC2_EN for a second-order CIC with first-frame suppression; default is first order.
module pdm_decoder #(
    parameter int CLK_DIV    = 1,
    parameter int LOG2_DECIM = 6,
    parameter int SAMPLE_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                pdm_in,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                clip
);

`ifdef PDM_DECODER_CIC2_EN
    localparam int N = 2;
`else
    localparam int N = 1;
`endif
    localparam int RW    = N * LOG2_DECIM + 1;
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SHIFT = SAMPLE_W - N * LOG2_DECIM;
    localparam int LSH   = (SHIFT > 0) ? SHIFT : 0;
    localparam int RSH   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int WW    = RW + SAMPLE_W + 1;

    // NOTE: the synchroniser carries no reset so it keeps tracking the pin while rst is high,
    // and the first frame after release sees live data instead of two forced zeros.
    logic [1:0] sync_q;
    logic       pdm_s;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], pdm_in};
    end
    assign pdm_s = sync_q[1];

    logic [PW-1:0]         presc_q;
    logic [LOG2_DECIM-1:0] dec_q;
    logic                  bit_stb;
    logic                  frame_stb;

    assign bit_stb   = en && (presc_q == PW'(CLK_DIV - 1));
    assign frame_stb = bit_stb && (dec_q == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            dec_q   <= '0;
        end else if (!en) begin
            presc_q <= '0;
            dec_q   <= '0;
        end else begin
            presc_q <= bit_stb ? '0 : presc_q + PW'(1);
            if (bit_stb) dec_q <= dec_q + LOG2_DECIM'(1);
        end
    end

    // Combs see the integrator values that already include the bit of the frame_stb cycle.
    logic [RW-1:0] int1_q, int1_n, dly1_q, raw_n, raw_q;
    logic          pend_q;
    logic          emit;

    assign int1_n = int1_q + RW'(pdm_s);

`ifdef PDM_DECODER_CIC2_EN
    logic [RW-1:0] int2_q, int2_n, dly2_q, comb1_n;
    logic          primed_q;

    assign int2_n  = int2_q + int1_n;
    assign comb1_n = int2_n - dly1_q;
    assign raw_n   = comb1_n - dly2_q;
    assign emit    = primed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int2_q   <= '0;
            dly2_q   <= '0;
            primed_q <= 1'b0;
        end else if (!en) begin
            int2_q   <= '0;
            dly2_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            if (bit_stb) int2_q <= int2_n;
            if (frame_stb) begin
                dly2_q   <= comb1_n;
                primed_q <= 1'b1;
            end
        end
    end

    logic [RW-1:0] dly1_d;
    assign dly1_d = int2_n;
`else
    assign raw_n = int1_n - dly1_q;
    assign emit  = 1'b1;

    logic [RW-1:0] dly1_d;
    assign dly1_d = int1_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int1_q <= '0;
            dly1_q <= '0;
            raw_q  <= '0;
            pend_q <= 1'b0;
        end else if (!en) begin
            int1_q <= '0;
            dly1_q <= '0;
            pend_q <= 1'b0;
        end else begin
            if (bit_stb) int1_q <= int1_n;
            if (frame_stb) begin
                dly1_q <= dly1_d;
                raw_q  <= raw_n;
            end
            pend_q <= frame_stb && emit;
        end
    end

    logic [WW-1:0]       scaled;
    logic                over;
    logic [SAMPLE_W-1:0] sat;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        scaled = '0;
        over   = 1'b0;
        sat    = '0;
        scaled = (WW'(raw_q) << LSH) >> RSH;
        over   = |scaled[WW-1:SAMPLE_W];
        sat    = over ? '1 : scaled[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
        end else if (!en) begin
            sample_valid <= 1'b0;
            clip         <= 1'b0;
        end else if (pend_q) begin
            sample       <= sat;
            sample_valid <= 1'b1;
            clip         <= clip | over;
        end else begin
            sample_valid <= 1'b0;
        end
    end

endmodule
